// File: rtl/palindrome_stream_sched.sv
// palindrome_stream_sched
//   One sliding-window palindrome checker shared by NUM_CH serial bit
//   requesters. A round-robin arbiter picks one channel per cycle. The checker
//   is context switched: each channel keeps its own window history and fill
//   count. The verdict for each accepted bit comes back one cycle later on a
//   single registered result port that supports backpressure.
module palindrome_stream_sched #(
   parameter int NUM_CH = 4,
   parameter int WIN    = 3,
   parameter int CNT_W  = 8,
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [NUM_CH-1:0] req_valid_i,
   input  logic [NUM_CH-1:0] req_bit_i,
   output logic [NUM_CH-1:0] req_ready_o,
   input  logic [NUM_CH-1:0] flush_i,
   output logic              res_valid_o,
   input  logic              res_ready_i,
   output logic [CH_W-1:0]   res_ch_o,
   output logic              res_pal_o,
   output logic [CNT_W-1:0]  hit_cnt_o
);

   localparam int FILL_W = $clog2(WIN + 1);

   // per-channel context: the last WIN-1 bits (newest at LSB) and how many
   // bits have arrived since reset/flush, saturating at WIN
   logic [WIN-2:0]    hist_q [NUM_CH];
   logic [WIN-2:0]    hist_d [NUM_CH];
   logic [FILL_W-1:0] fill_q [NUM_CH];
   logic [FILL_W-1:0] fill_d [NUM_CH];

   logic [CH_W-1:0]   ptr_q, ptr_d;
   logic              res_valid_q, res_valid_d;
   logic [CH_W-1:0]   res_ch_q, res_ch_d;
   logic              res_pal_q, res_pal_d;
   logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;

   logic              slot_free;
   logic [NUM_CH-1:0] eligible;
   logic [NUM_CH-1:0] grant;
   logic [CH_W-1:0]   gnt_idx;
   logic              accept;
   int                arb_idx;

   logic [WIN-1:0]    win;
   logic [WIN-1:0]    win_rev;
   logic              pal_now;

   // round-robin search starting one past the last granted channel; a channel
   // being flushed is skipped so its bit stays pending at the requester
   always_comb begin
      slot_free = !res_valid_q || res_ready_i;
      eligible  = req_valid_i & ~flush_i;
      grant     = '0;
      gnt_idx   = '0;
      arb_idx   = 0;
      for (int i = 1; i <= NUM_CH; i++) begin
         arb_idx = (int'(ptr_q) + i) % NUM_CH;
         if (reset_n && slot_free && (grant == '0) && eligible[arb_idx]) begin
            grant[arb_idx] = 1'b1;
            gnt_idx        = arb_idx[CH_W-1:0];
         end
      end
   end

   assign accept      = |grant;
   assign req_ready_o = grant;

   // window of the granted channel including the bit being accepted, and the
   // palindrome verdict (only valid once a full window has been received)
   always_comb begin
      win     = {hist_q[gnt_idx], req_bit_i[gnt_idx]};
      win_rev = '0;
      for (int i = 0; i < WIN; i++) begin
         win_rev[i] = win[WIN-1-i];
      end
      pal_now = (win == win_rev) && (fill_q[gnt_idx] >= FILL_W'(WIN - 1));
   end

   // next context per channel: flush wins (a flushed channel is never granted)
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         hist_d[c] = hist_q[c];
         fill_d[c] = fill_q[c];
         if (flush_i[c]) begin
            hist_d[c] = '0;
            fill_d[c] = '0;
         end else if (accept && (gnt_idx == CH_W'(c))) begin
            hist_d[c] = win[WIN-2:0];
            if (fill_q[c] != FILL_W'(WIN)) begin
               fill_d[c] = fill_q[c] + 1'b1;
            end
         end
      end
   end

   // result slot: load on accept, drop when taken with nothing new behind it,
   // otherwise hold; the hit counter counts palindromic results as they are taken
   always_comb begin
      res_valid_d = res_valid_q;
      res_ch_d    = res_ch_q;
      res_pal_d   = res_pal_q;
      hit_cnt_d   = hit_cnt_q;
      ptr_d       = ptr_q;
      if (accept) begin
         res_valid_d = 1'b1;
         res_ch_d    = gnt_idx;
         res_pal_d   = pal_now;
         ptr_d       = gnt_idx;
      end else if (res_ready_i) begin
         res_valid_d = 1'b0;
      end
      if (res_valid_q && res_ready_i && res_pal_q && !(&hit_cnt_q)) begin
         hit_cnt_d = hit_cnt_q + 1'b1;
      end
   end

   // state registers; pointer resets to the last channel so ch0 is searched first
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int c = 0; c < NUM_CH; c++) begin
            hist_q[c] <= '0;
            fill_q[c] <= '0;
         end
         ptr_q       <= CH_W'(NUM_CH - 1);
         res_valid_q <= 1'b0;
         res_ch_q    <= '0;
         res_pal_q   <= 1'b0;
         hit_cnt_q   <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            hist_q[c] <= hist_d[c];
            fill_q[c] <= fill_d[c];
         end
         ptr_q       <= ptr_d;
         res_valid_q <= res_valid_d;
         res_ch_q    <= res_ch_d;
         res_pal_q   <= res_pal_d;
         hit_cnt_q   <= hit_cnt_d;
      end
   end

   assign res_valid_o = res_valid_q;
   assign res_ch_o    = res_ch_q;
   assign res_pal_o   = res_pal_q;
   assign hit_cnt_o   = hit_cnt_q;

endmodule

// File: tb/tb_palindrome_stream_sched.sv
// Testbench for palindrome_stream_sched: reference model plus result
// scoreboard; a second instance with CNT_W=2 shares the stimulus to observe
// hit counter saturation.
module tb_palindrome_stream_sched;

   localparam int N = 4;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [3:0] req_valid, req_bit, flush;
   logic       res_ready;
   logic [3:0] req_ready, req_ready2;
   logic       res_valid, res_pal, res_valid2, res_pal2;
   logic [1:0] res_ch, res_ch2;
   logic [7:0] hit_cnt;
   logic [1:0] hit_cnt2;

   always #5 clk = ~clk;

   palindrome_stream_sched #(.NUM_CH(4), .WIN(3), .CNT_W(8)) dut (
      .clk(clk), .reset_n(reset_n), .req_valid_i(req_valid), .req_bit_i(req_bit),
      .req_ready_o(req_ready), .flush_i(flush), .res_valid_o(res_valid),
      .res_ready_i(res_ready), .res_ch_o(res_ch), .res_pal_o(res_pal), .hit_cnt_o(hit_cnt));

   palindrome_stream_sched #(.NUM_CH(4), .WIN(3), .CNT_W(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .req_valid_i(req_valid), .req_bit_i(req_bit),
      .req_ready_o(req_ready2), .flush_i(flush), .res_valid_o(res_valid2),
      .res_ready_i(res_ready), .res_ch_o(res_ch2), .res_pal_o(res_pal2), .hit_cnt_o(hit_cnt2));

   typedef struct {
      logic [1:0] ch;
      logic       pal;
   } res_t;

   res_t       sb_q[$];
   logic [1:0] m_hist [N];
   int         m_fill [N];
   int         m_ptr;
   int         m_hit8, m_hit2;
   int         vectors = 0;
   int         miscompares = 0;

   function automatic logic [3:0] exp_grant();
      if (reset_n !== 1'b1) return 4'b0000;
      if (sb_q.size() != 0 && res_ready !== 1'b1) return 4'b0000;
      for (int i = 1; i <= N; i++) begin
         int k = (m_ptr + i) % N;
         if (req_valid[k] && !flush[k]) return 4'(1 << k);
      end
      return 4'b0000;
   endfunction

   task automatic model_reset();
      sb_q.delete();
      for (int c = 0; c < N; c++) begin
         m_hist[c] = 2'b00;
         m_fill[c] = 0;
      end
      m_ptr  = N - 1;
      m_hit8 = 0;
      m_hit2 = 0;
   endtask

   // advance one clock: model edge update, then sample point 1ns after edge
   task automatic tick();
      logic [3:0] g;
      logic [2:0] win;
      res_t       r;
      int         k;
      g = exp_grant();
      @(posedge clk);
      if (sb_q.size() != 0 && res_ready) begin
         r = sb_q.pop_front();
         if (r.pal) begin
            if (m_hit8 < 255) m_hit8++;
            if (m_hit2 < 3) m_hit2++;
         end
      end
      if (g != 4'b0000) begin
         k = 0;
         for (int c = 0; c < N; c++) if (g[c]) k = c;
         win   = {m_hist[k], req_bit[k]};
         r.ch  = 2'(k);
         r.pal = (win[0] == win[2]) && (m_fill[k] >= 2);
         sb_q.push_back(r);
         m_hist[k] = win[1:0];
         if (m_fill[k] < 3) m_fill[k]++;
         m_ptr = k;
      end
      for (int c = 0; c < N; c++) begin
         if (flush[c]) begin
            m_hist[c] = 2'b00;
            m_fill[c] = 0;
         end
      end
      #1;
   endtask

   task automatic apply_reset();
      reset_n = 1'b0; req_valid = '0; req_bit = '0; flush = '0; res_ready = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; req_valid = 4'b1111; req_bit = '0; flush = '0; res_ready = 1'b1;
      model_reset();
      @(posedge clk);
      #2;
      vectors++;
      if (req_ready !== 4'b0000 || res_valid !== 1'b0 || res_ch !== 2'd0 || res_pal !== 1'b0 || hit_cnt !== 8'd0) begin
         miscompares++;
         $display("FAIL reset_state: got rdy=%b v=%b ch=%0d pal=%b hit=%0d want 0000 0 0 0 0",
                  req_ready, res_valid, res_ch, res_pal, hit_cnt);
      end
      @(posedge clk);
      #1 reset_n = 1'b1;
      #1;
      vectors++;
      if (req_ready !== 4'b0001) begin
         miscompares++;
         $display("FAIL reset_first_grant: got %b want 0001", req_ready);
      end
      req_valid = '0;
      #1;
   endtask

   task automatic test_single();
      logic bits_c [3] = '{1'b1, 1'b0, 1'b1};
      logic pal_c  [3] = '{1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 5; i++) begin
         req_valid = (i < 3) ? 4'b0001 : 4'b0000;
         req_bit   = {3'b000, (i < 3) ? bits_c[i] : 1'b0};
         res_ready = 1'b1;
         #2;
         vectors++;
         if (req_ready !== exp_grant()) begin
            miscompares++;
            $display("FAIL single_grant[%0d]: got %b want %b", i, req_ready, exp_grant());
         end
         vectors++;
         if (sb_q.size() == 0) begin
            if (res_valid !== 1'b0) begin
               miscompares++;
               $display("FAIL single_result[%0d]: got v=%b want v=0", i, res_valid);
            end
         end else if (res_valid !== 1'b1 || res_ch !== sb_q[0].ch || res_pal !== sb_q[0].pal) begin
            miscompares++;
            $display("FAIL single_result[%0d]: got v=%b ch=%0d pal=%b want v=1 ch=%0d pal=%b",
                     i, res_valid, res_ch, res_pal, sb_q[0].ch, sb_q[0].pal);
         end
         if (i >= 1 && i <= 3) begin
            vectors++;
            if (res_ch !== 2'd0 || res_pal !== pal_c[i-1]) begin
               miscompares++;
               $display("FAIL single_pal_seq[%0d]: got ch=%0d pal=%b want ch=0 pal=%b", i, res_ch, res_pal, pal_c[i-1]);
            end
         end
         tick();
      end
      vectors++;
      if (hit_cnt !== 8'd1) begin
         miscompares++;
         $display("FAIL single_hit_cnt: got %0d want 1", hit_cnt);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] seq_c [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      apply_reset();
      for (int i = 0; i < 7; i++) begin
         req_valid = (i < 5) ? 4'b1111 : 4'b0000;
         req_bit   = 4'($urandom_range(0, 15));
         res_ready = 1'b1;
         #2;
         vectors++;
         if (req_ready !== exp_grant()) begin
            miscompares++;
            $display("FAIL rr_grant[%0d]: got %b want %b", i, req_ready, exp_grant());
         end
         if (i < 5) begin
            vectors++;
            if (req_ready !== seq_c[i]) begin
               miscompares++;
               $display("FAIL rr_sequence[%0d]: got %b want %b", i, req_ready, seq_c[i]);
            end
         end
         vectors++;
         if (sb_q.size() == 0) begin
            if (res_valid !== 1'b0) begin
               miscompares++;
               $display("FAIL rr_result[%0d]: got v=%b want v=0", i, res_valid);
            end
         end else if (res_valid !== 1'b1 || res_ch !== sb_q[0].ch || res_pal !== sb_q[0].pal) begin
            miscompares++;
            $display("FAIL rr_result[%0d]: got v=%b ch=%0d pal=%b want v=1 ch=%0d pal=%b",
                     i, res_valid, res_ch, res_pal, sb_q[0].ch, sb_q[0].pal);
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      logic rdy_c [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 7; i++) begin
         req_valid = (i < 5) ? 4'b1111 : 4'b0000;
         req_bit   = 4'($urandom_range(0, 15));
         res_ready = rdy_c[i];
         #2;
         vectors++;
         if (req_ready !== exp_grant()) begin
            miscompares++;
            $display("FAIL bp_grant[%0d]: got %b want %b", i, req_ready, exp_grant());
         end
         if (i >= 1 && i <= 3) begin
            vectors++;
            if (req_ready !== 4'b0000) begin
               miscompares++;
               $display("FAIL bp_stall_grant[%0d]: got %b want 0000", i, req_ready);
            end
         end
         if (i == 4) begin
            vectors++;
            if (req_ready !== 4'b0100) begin
               miscompares++;
               $display("FAIL bp_resume_grant: got %b want 0100", req_ready);
            end
         end
         vectors++;
         if (sb_q.size() == 0) begin
            if (res_valid !== 1'b0) begin
               miscompares++;
               $display("FAIL bp_result[%0d]: got v=%b want v=0", i, res_valid);
            end
         end else if (res_valid !== 1'b1 || res_ch !== sb_q[0].ch || res_pal !== sb_q[0].pal) begin
            miscompares++;
            $display("FAIL bp_result[%0d]: got v=%b ch=%0d pal=%b want v=1 ch=%0d pal=%b",
                     i, res_valid, res_ch, res_pal, sb_q[0].ch, sb_q[0].pal);
         end
         tick();
      end
   endtask

   task automatic test_flush();
      logic v_c [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic b_c [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      logic f_c [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      logic pal_c [3] = '{1'b0, 1'b0, 1'b1};
      apply_reset();
      for (int i = 0; i < 8; i++) begin
         req_valid = {2'b00, v_c[i], 1'b0};
         req_bit   = {2'b00, b_c[i], 1'b0};
         flush     = {2'b00, f_c[i], 1'b0};
         res_ready = 1'b1;
         #2;
         vectors++;
         if (req_ready !== exp_grant()) begin
            miscompares++;
            $display("FAIL flush_grant[%0d]: got %b want %b", i, req_ready, exp_grant());
         end
         if (i == 2) begin
            vectors++;
            if (req_ready[1] !== 1'b0) begin
               miscompares++;
               $display("FAIL flush_blocks_accept: got %b want 0", req_ready[1]);
            end
         end
         vectors++;
         if (sb_q.size() == 0) begin
            if (res_valid !== 1'b0) begin
               miscompares++;
               $display("FAIL flush_result[%0d]: got v=%b want v=0", i, res_valid);
            end
         end else if (res_valid !== 1'b1 || res_ch !== sb_q[0].ch || res_pal !== sb_q[0].pal) begin
            miscompares++;
            $display("FAIL flush_result[%0d]: got v=%b ch=%0d pal=%b want v=1 ch=%0d pal=%b",
                     i, res_valid, res_ch, res_pal, sb_q[0].ch, sb_q[0].pal);
         end
         if (i >= 4 && i <= 6) begin
            vectors++;
            if (res_valid !== 1'b1 || res_ch !== 2'd1 || res_pal !== pal_c[i-4]) begin
               miscompares++;
               $display("FAIL flush_refill_pal[%0d]: got v=%b ch=%0d pal=%b want v=1 ch=1 pal=%b",
                        i, res_valid, res_ch, res_pal, pal_c[i-4]);
            end
         end
         tick();
      end
      flush = '0;
   endtask

   task automatic test_reset_mid();
      logic [3:0] v_c [5] = '{4'b0100, 4'b0100, 4'b0000, 4'b0101, 4'b0100};
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         req_valid = v_c[i];
         req_bit   = (i == 0) ? 4'b0100 : 4'b0000;
         res_ready = (i < 2);
         #2;
         vectors++;
         if (req_ready !== exp_grant()) begin
            miscompares++;
            $display("FAIL rstmid_grant[%0d]: got %b want %b", i, req_ready, exp_grant());
         end
         tick();
      end
      vectors++;
      if (res_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL rstmid_pending: got v=%b want v=1", res_valid);
      end
      req_valid = 4'b0100;
      #2 reset_n = 1'b0;
      #1;
      vectors++;
      if (res_valid !== 1'b0 || req_ready !== 4'b0000) begin
         miscompares++;
         $display("FAIL rstmid_async_drop: got v=%b rdy=%b want v=0 rdy=0000", res_valid, req_ready);
      end
      model_reset();
      @(posedge clk);
      #1 reset_n = 1'b1;
      for (int i = 3; i < 7; i++) begin
         req_valid = (i < 5) ? v_c[i] : 4'b0000;
         req_bit   = 4'b0001;
         res_ready = 1'b1;
         #2;
         vectors++;
         if (req_ready !== exp_grant()) begin
            miscompares++;
            $display("FAIL rstmid_grant[%0d]: got %b want %b", i, req_ready, exp_grant());
         end
         if (i == 3) begin
            vectors++;
            if (req_ready !== 4'b0001) begin
               miscompares++;
               $display("FAIL rstmid_first_grant: got %b want 0001", req_ready);
            end
         end
         if (i == 5) begin
            vectors++;
            if (res_valid !== 1'b1 || res_ch !== 2'd2 || res_pal !== 1'b0) begin
               miscompares++;
               $display("FAIL rstmid_ch2_result: got v=%b ch=%0d pal=%b want v=1 ch=2 pal=0",
                        res_valid, res_ch, res_pal);
            end
         end
         vectors++;
         if (sb_q.size() == 0) begin
            if (res_valid !== 1'b0) begin
               miscompares++;
               $display("FAIL rstmid_result[%0d]: got v=%b want v=0", i, res_valid);
            end
         end else if (res_valid !== 1'b1 || res_ch !== sb_q[0].ch || res_pal !== sb_q[0].pal) begin
            miscompares++;
            $display("FAIL rstmid_result[%0d]: got v=%b ch=%0d pal=%b want v=1 ch=%0d pal=%b",
                     i, res_valid, res_ch, res_pal, sb_q[0].ch, sb_q[0].pal);
         end
         tick();
      end
   endtask

   task automatic test_saturate();
      apply_reset();
      for (int i = 0; i < 8; i++) begin
         req_valid = (i < 6) ? 4'b1000 : 4'b0000;
         req_bit   = 4'b0000;
         res_ready = 1'b1;
         #2;
         vectors++;
         if (req_ready !== exp_grant()) begin
            miscompares++;
            $display("FAIL sat_grant[%0d]: got %b want %b", i, req_ready, exp_grant());
         end
         vectors++;
         if (sb_q.size() == 0) begin
            if (res_valid !== 1'b0) begin
               miscompares++;
               $display("FAIL sat_result[%0d]: got v=%b want v=0", i, res_valid);
            end
         end else if (res_valid !== 1'b1 || res_ch !== sb_q[0].ch || res_pal !== sb_q[0].pal) begin
            miscompares++;
            $display("FAIL sat_result[%0d]: got v=%b ch=%0d pal=%b want v=1 ch=%0d pal=%b",
                     i, res_valid, res_ch, res_pal, sb_q[0].ch, sb_q[0].pal);
         end
         vectors++;
         if (hit_cnt2 !== 2'(m_hit2) || hit_cnt !== 8'(m_hit8)) begin
            miscompares++;
            $display("FAIL sat_hit_cnt[%0d]: got w2=%0d w8=%0d want w2=%0d w8=%0d",
                     i, hit_cnt2, hit_cnt, m_hit2, m_hit8);
         end
         tick();
      end
      vectors++;
      if (hit_cnt2 !== 2'd3 || hit_cnt !== 8'd4) begin
         miscompares++;
         $display("FAIL sat_final: got w2=%0d w8=%0d want w2=3 w8=4", hit_cnt2, hit_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_saturate();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
